aespim_accel: RTL and testbench

- Processing-in-memory style AES-GCM helper; sits beside the core load/store path.
- Accumulates 32x32 carry-less partial products of two 128-bit operands into a 255-bit product, issued one word pair per command.
- Reduces the product modulo the GCM polynomial x^128+x^7+x^2+x+1 (non-reflected bit order).
- Streams the 128-bit result back one 32-bit word per store command.

---
 rtl/aespim_accel.sv | 57 +++++
 tb/tb_aespim_accel.sv | 88 ++++++++
 2 files changed

// File: rtl/aespim_accel.sv
// aespim_accel: GCM carry-less multiply-accumulate with modular reduction and word readout
package aespim_pkg;
  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_GMUL = 3'b001;
  localparam logic [2:0] OP_ST   = 3'b010;
endpackage

module aespim_accel
  import aespim_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [5:0]  op_code_i,
  input  logic [31:0] data_in_mem_i,
  input  logic [31:0] data_in_reg_i,
  output logic [31:0] data_out_o,
  output logic        done_o
);
  logic [254:0] acc, r;
  logic [62:0]  p;
  logic [1:0]   rd_ptr;
  logic [2:0]   op, s;
  logic         gmul, st;
  assign op   = op_code_i[2:0];
  assign s    = op_code_i[5:3];
  assign gmul = start_i && op == OP_GMUL && s != 3'd7;
  assign st   = start_i && op == OP_ST;
  always_comb begin
    p = '0;
    for (int j = 0; j < 32; j++) p = data_in_mem_i[j] ? p ^ (63'(data_in_reg_i) << j) : p;
  end
  always_comb begin
    r = acc;
    for (int i = 254; i >= 128; i--) begin
      if (r[i]) begin
        r[i-121] = ~r[i-121];
        r[i-126] = ~r[i-126];
        r[i-127] = ~r[i-127];
        r[i-128] = ~r[i-128];
      end
    end
  end
  assign data_out_o = r[{rd_ptr, 5'b0} +: 32];
  assign done_o     = st && rd_ptr == 2'd3;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc    <= '0;
      rd_ptr <= '0;
    end else if (gmul) begin
      acc <= acc ^ (255'(p) << {s, 5'b0});
    end else if (st) begin
      rd_ptr <= rd_ptr + 2'd1;
      acc    <= rd_ptr == 2'd3 ? '0 : acc;
    end
  end
endmodule

// File: tb/tb_aespim_accel.sv
// tb_aespim_accel: directed self-checking bench for aespim_accel
module tb_aespim_accel;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [5:0]  op_code_i;
  logic [31:0] data_in_mem_i, data_in_reg_i, data_out_o;
  logic        done_o;
  int          tests = 0;
  int          fails = 0;
  logic [127:0] ga, gb, ia, ib, ra, rb;
  logic [31:0]  gexp [4];
  always #5 clk_i = ~clk_i;
  aespim_accel dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .op_code_i(op_code_i),
    .data_in_mem_i(data_in_mem_i), .data_in_reg_i(data_in_reg_i),
    .data_out_o(data_out_o), .done_o(done_o)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask
  task automatic gmul(input logic [31:0] a, input logic [31:0] b, input logic [2:0] s);
    start_i = 1'b1; op_code_i = {s, 3'b001}; data_in_reg_i = a; data_in_mem_i = b;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask
  task automatic full_mul(input logic [127:0] a, input logic [127:0] b);
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++)
        gmul(a[32*i +: 32], b[32*k +: 32], 3'(i + k));
  endtask
  task automatic st_read(input string tag, input logic [31:0] exp, input logic exp_done);
    start_i = 1'b1; op_code_i = 6'b000_010;
    #1;
    chk({tag, " data"}, data_out_o, exp);
    chk({tag, " done"}, {31'b0, done_o}, {31'b0, exp_done});
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask
  initial begin
    ga = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    gb = 128'h0388dace60b6a392f328c2b971b2fe78;
    gexp = '{32'h31167f1c, 32'h9c1eb217, 32'hc731568e, 32'h519fa38a};
    ra = 128'h80000000_00000000_00000000_00000000;
    rb = 128'h00000000_00000000_00000000_00000002;
    ia = 128'h1;
    ib = 128'h12345678_9abcdef0_0fedcba9_87654321;
    rst_ni = 1'b0; start_i = 1'b0; op_code_i = '0; data_in_mem_i = '0; data_in_reg_i = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    #1;
    chk("reset data", data_out_o, 32'h0);
    chk("reset done", {31'b0, done_o}, 32'h0);
    for (int w = 0; w < 4; w++) st_read($sformatf("zero w%0d", w), 32'h0, w == 3);
    for (int rep = 0; rep < 2; rep++) begin
      full_mul(ga, gb);
      for (int w = 0; w < 4; w++) st_read($sformatf("gcm%0d w%0d", rep, w), gexp[w], w == 3);
    end
    gmul(ra[127:96], rb[31:0], 3'd3);
    start_i = 1'b0; op_code_i = 6'b000_001; data_in_reg_i = 32'hffffffff; data_in_mem_i = 32'hffffffff;
    @(posedge clk_i); #1;
    chk("idle done", {31'b0, done_o}, 32'h0);
    gmul(32'hffffffff, 32'hffffffff, 3'd7);
    start_i = 1'b1; op_code_i = 6'b000_111;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    st_read("red w0", 32'h00000087, 1'b0);
    st_read("red w1", 32'h0, 1'b0);
    st_read("red w2", 32'h0, 1'b0);
    st_read("red w3", 32'h0, 1'b1);
    full_mul(ia, ib);
    for (int w = 0; w < 4; w++) st_read($sformatf("ident w%0d", w), ib[32*w +: 32], w == 3);
    full_mul(ga, gb);
    st_read("pre-reset w0", gexp[0], 1'b0);
    #2 rst_ni = 1'b0;
    #1;
    chk("async reset data", data_out_o, 32'h0);
    chk("async reset done", {31'b0, done_o}, 32'h0);
    @(posedge clk_i); #1 rst_ni = 1'b1;
    st_read("post-reset w0", 32'h0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
